if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, SHALL be the instruction driven whenever no valid fetch is presented.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stall  input  1  SHALL indicate the IF/ID register is holding; 1 = do not consume outputs this edge.
REQ-006 branch_taken  input  1  SHALL be a one-cycle redirect request.
REQ-007 branch_target  input  64  SHALL be the redirect PC, sampled when branch_taken=1.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-009 imem_addr  output  64  SHALL be the fetch address, held stable while imem_req=1.
REQ-010 imem_rdata  input  32  SHALL be the instruction word, valid when imem_valid=1.
REQ-011 imem_valid  input  1  SHALL be the one-cycle response strobe for the current imem_addr.
REQ-012 Instruction  output  32  SHALL be the fetched instruction, registered.
REQ-013 PC_Out  output  64  SHALL be the PC of Instruction, registered.
REQ-014 adder_out1  output  64  SHALL be PC_Out+4, registered.
REQ-015 fetch_valid  output  1  SHALL be 1 when Instruction/PC_Out/adder_out1 hold a real fetch.

Function
REQ-016 A transfer SHALL occur on every edge with fetch_valid=1 and stall=0; the output slot is then free unless reloaded on that same edge.
REQ-017 A one-entry skid buffer {instr, pc} SHALL hold a response that arrives while the output slot is occupied and stall=1.
REQ-018 States SHALL be IDLE, REQ, WAIT, FLUSH; imem_req=1 only in REQ.
REQ-019 IDLE SHALL last exactly one cycle after reset, then go to REQ.
REQ-020 In REQ, imem_addr SHALL equal pc; imem_valid may assert in any REQ cycle, including the first.
REQ-021 REQ with imem_valid and slot free-or-transferring SHALL load slot {imem_rdata, pc, pc+4}, set fetch_valid=1, set pc<=pc+4, and remain in REQ.
REQ-022 REQ with imem_valid, slot occupied and stall=1 SHALL load the skid buffer, set pc<=pc+4, and go to WAIT.
REQ-023 WAIT SHALL hold the slot and skid unchanged until a transfer edge, then move the skid into the slot (fetch_valid=1) and go to REQ.
REQ-024 After a transfer with no reload, the outputs SHALL be Instruction=NOP_INSTR, fetch_valid=0; PC_Out/adder_out1 keep their last values.
REQ-025 branch_taken=1 SHALL take priority over stall and all other events (except reset): pc<=branch_target with bits [1:0] forced to 0, slot and skid invalidated (fetch_valid=0, Instruction=NOP_INSTR), and any imem_valid on that edge discarded.
REQ-026 On redirect, next state SHALL be FLUSH if in REQ without imem_valid that cycle; otherwise REQ.
REQ-027 FLUSH SHALL keep imem_req=0 and discard the next imem_valid response, then go to REQ.
REQ-028 A branch_taken during FLUSH SHALL update pc and remain in FLUSH.
REQ-029 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-030 At most one memory request SHALL be outstanding at any time.

Reset
REQ-031 On reset=1 at a rising edge: pc=RESET_PC, state=IDLE, fetch_valid=0, Instruction=NOP_INSTR, PC_Out=0, adder_out1=0, skid invalid, imem_req=0.
REQ-032 Reset asserted mid-operation SHALL abandon any outstanding request; a stray imem_valid in the following IDLE cycle SHALL be ignored.

Verification
REQ-033 Reset, then 0-latency memory, stall=0 -> PC_Out sequence 0,4,8,C with fetch_valid=1 on consecutive cycles from cycle 2.
REQ-034 stall=1 for 3 cycles while slot holds PC 8 and response for C arrives -> state WAIT, outputs hold PC 8; after stall drops, PC C is presented next cycle, then fetch resumes at 10.
REQ-035 branch_taken with target 64'h103 while a 3-cycle-latency request for 14 is outstanding -> FLUSH, response for 14 discarded, next imem_addr=100, fetch_valid=0 until its response.
REQ-036 branch_taken and imem_valid on the same edge, stall=1 -> response dropped, fetch_valid=0, next state REQ, imem_addr=target.
REQ-037 pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> adder_out1=0 and next imem_addr=0.
REQ-038 Reset asserted while in WAIT -> all outputs at reset values next cycle; first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// One request is outstanding at a time, and each request is answered by a one-cycle valid strobe.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues sequential fetches, presents them in a registered IF/ID slot
// with a one-entry skid buffer, and redirects on taken branches.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [63:0]     branch_target,
    if_fetch_unit_if.master imem,
    output logic [31:0]     Instruction,
    output logic [63:0]     PC_Out,
    output logic [63:0]     adder_out1,
    output logic            fetch_valid
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

    state_t      state;
    logic        req_q;
    logic [63:0] pc;
    logic [31:0] skid_instr;
    logic [63:0] skid_pc;
    logic        skid_valid;

    logic        transfer;
    logic        slot_free;
    logic [63:0] pc_plus4;
    logic [63:0] skid_pc_plus4;
    logic [63:0] redirect_pc;

    assign transfer      = fetch_valid && !stall;
    assign slot_free     = !fetch_valid || !stall;
    assign pc_plus4      = pc + 64'd4;
    assign skid_pc_plus4 = skid_pc + 64'd4;
    assign redirect_pc   = branch_target & ~64'd3;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // Whole fetch FSM; the request strobe is registered alongside every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            Instruction <= NOP_INSTR;
            PC_Out      <= 64'h0;
            adder_out1  <= 64'h0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 64'h0;
        end else if (branch_taken) begin
            pc          <= redirect_pc;
            fetch_valid <= 1'b0;
            Instruction <= NOP_INSTR;
            skid_valid  <= 1'b0;
            // A response arriving on this edge means nothing is left in flight to flush.
            if (!imem.imem_valid && (state == REQ || state == FLUSH)) begin
                state <= FLUSH;
                req_q <= 1'b0;
            end else begin
                state <= REQ;
                req_q <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_valid && slot_free) begin
                        Instruction <= imem.imem_rdata;
                        PC_Out      <= pc;
                        adder_out1  <= pc_plus4;
                        fetch_valid <= 1'b1;
                        pc          <= pc_plus4;
                    end else if (imem.imem_valid) begin
                        skid_instr <= imem.imem_rdata;
                        skid_pc    <= pc;
                        skid_valid <= 1'b1;
                        pc         <= pc_plus4;
                        state      <= WAIT;
                        req_q      <= 1'b0;
                    end else if (transfer) begin
                        fetch_valid <= 1'b0;
                        Instruction <= NOP_INSTR;
                    end
                end
                WAIT: begin
                    if (transfer && skid_valid) begin
                        Instruction <= skid_instr;
                        PC_Out      <= skid_pc;
                        adder_out1  <= skid_pc_plus4;
                        fetch_valid <= 1'b1;
                        skid_valid  <= 1'b0;
                        state       <= REQ;
                        req_q       <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (transfer) begin
                        fetch_valid <= 1'b0;
                        Instruction <= NOP_INSTR;
                    end
                    if (imem.imem_valid) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // An unanswered request keeps its address, and an empty slot always shows the NOP.
    property p_addr_stable;
        @(posedge clk) disable iff (reset)
            (state == REQ && !imem.imem_valid && !branch_taken)
                |=> (state == REQ && imem.imem_addr == $past(imem.imem_addr));
    endproperty
    assert property (p_addr_stable);

    assert property (@(posedge clk) disable iff (reset) !fetch_valid |-> Instruction == NOP_INSTR);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, multi-cycle corner sequences, and a randomized run
// checked against a program-order model of the fetched instruction stream.
module tb_if_fetch_unit;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam int          NVEC     = 17;

    typedef struct {
        bit          rst;
        bit          st;
        bit          br;
        logic [63:0] tgt;
        bit          fv;
        logic [63:0] pc_out;
        logic [63:0] adder;
        bit          req;
        logic [63:0] addr;
    } vec_t;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        stall         = 1'b0;
    logic        branch_taken  = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] Instruction;
    logic [63:0] PC_Out;
    logic [63:0] adder_out1;
    logic        fetch_valid;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem         (bus),
        .Instruction  (Instruction),
        .PC_Out       (PC_Out),
        .adder_out1   (adder_out1),
        .fetch_valid  (fetch_valid)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    bit          mem_auto     = 1'b1;
    bit          mem_rand     = 1'b0;
    int          mem_fixed_lat = 0;
    bit          mem_pending  = 1'b0;
    int          mem_cnt      = 0;
    logic [63:0] mem_addr     = 64'h0;
    bit          force_valid  = 1'b0;
    logic [31:0] force_rdata  = 32'h0;
    logic [63:0] exp_pc       = RESET_PC;
    int          transfers    = 0;
    vec_t        vecs [NVEC];

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
        end
    endtask

    // Memory model: answers each request after a fixed or random latency, one at a time.
    task automatic driveMemory(input bit rst);
        int lat;
        bus.imem_valid = 1'b0;
        if (rst) begin
            mem_pending = 1'b0;
        end else if (!mem_auto) begin
            bus.imem_valid = force_valid;
            bus.imem_rdata = force_rdata;
        end else if (mem_pending) begin
            if (bus.imem_req === 1'b1) checkOutput("addr_hold", bus.imem_addr, mem_addr);
            if (mem_cnt == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = word_at(mem_addr);
                mem_pending    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (bus.imem_req === 1'b1) begin
            lat      = mem_rand ? int'($urandom_range(0, 3)) : mem_fixed_lat;
            mem_addr = bus.imem_addr;
            if (lat == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = word_at(mem_addr);
            end else begin
                mem_pending = 1'b1;
                mem_cnt     = lat - 1;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check the consumed stream, return #1 after the rising edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit br, input logic [63:0] tgt);
        bit          hold;
        logic [63:0] hold_pc;
        logic [31:0] hold_instr;
        @(negedge clk);
        reset         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        driveMemory(rst);
        #1;
        if (!rst) begin
            if (fetch_valid !== 1'b1) begin
                checkOutput("nop_when_empty", Instruction, NOP);
            end else if (!st) begin
                checkOutput("stream_pc", PC_Out, exp_pc);
                checkOutput("stream_instr", Instruction, word_at(exp_pc));
                checkOutput("stream_adder", adder_out1, exp_pc + 64'd4);
                exp_pc = PC_Out + 64'd4;
                transfers++;
            end
            if (br) exp_pc = tgt & ~64'd3;
        end else begin
            exp_pc = RESET_PC;
        end
        hold       = !rst && !br && st && (fetch_valid === 1'b1);
        hold_pc    = PC_Out;
        hold_instr = Instruction;
        @(posedge clk);
        #1;
        if (hold) begin
            checkOutput("stall_hold_fv", fetch_valid, 1);
            checkOutput("stall_hold_pc", PC_Out, hold_pc);
            checkOutput("stall_hold_instr", Instruction, hold_instr);
        end
    endtask

    initial begin
        bit found;
        bit seen_req;
        int low_cycles;
        int start_transfers;
        logic [63:0] tgt;

        vecs[0]  = '{1, 0, 0, 64'h0,   0, 64'h0,   64'h0,   0, 64'h0};
        vecs[1]  = '{0, 0, 0, 64'h0,   0, 64'h0,   64'h0,   1, 64'h0};
        vecs[2]  = '{0, 0, 0, 64'h0,   1, 64'h0,   64'h4,   1, 64'h4};
        vecs[3]  = '{0, 0, 0, 64'h0,   1, 64'h4,   64'h8,   1, 64'h8};
        vecs[4]  = '{0, 0, 0, 64'h0,   1, 64'h8,   64'hC,   1, 64'hC};
        vecs[5]  = '{0, 1, 0, 64'h0,   1, 64'h8,   64'hC,   0, 64'h10};
        vecs[6]  = '{0, 1, 0, 64'h0,   1, 64'h8,   64'hC,   0, 64'h10};
        vecs[7]  = '{0, 1, 0, 64'h0,   1, 64'h8,   64'hC,   0, 64'h10};
        vecs[8]  = '{0, 0, 0, 64'h0,   1, 64'hC,   64'h10,  1, 64'h10};
        vecs[9]  = '{0, 0, 0, 64'h0,   1, 64'h10,  64'h14,  1, 64'h14};
        vecs[10] = '{0, 1, 1, 64'h203, 0, 64'h10,  64'h14,  1, 64'h200};
        vecs[11] = '{0, 0, 0, 64'h0,   1, 64'h200, 64'h204, 1, 64'h204};
        vecs[12] = '{0, 0, 0, 64'h0,   1, 64'h204, 64'h208, 1, 64'h208};
        vecs[13] = '{0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h204, 64'h208, 1, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[14] = '{0, 0, 0, 64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 64'h0};
        vecs[15] = '{0, 0, 0, 64'h0,   1, 64'h0,   64'h4,   1, 64'h4};
        vecs[16] = '{1, 0, 0, 64'h0,   0, 64'h0,   64'h0,   0, 64'h0};

        // Zero-latency memory: sequential fetch, skid through a stall, redirects, and PC wrap.
        mem_fixed_lat = 0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].br, vecs[i].tgt);
            checkOutput($sformatf("vec%0d_fv", i), fetch_valid, vecs[i].fv);
            checkOutput($sformatf("vec%0d_pc", i), PC_Out, vecs[i].pc_out);
            checkOutput($sformatf("vec%0d_adder", i), adder_out1, vecs[i].adder);
            checkOutput($sformatf("vec%0d_instr", i), Instruction, vecs[i].fv ? {32'h0, word_at(vecs[i].pc_out)} : {32'h0, NOP});
            checkOutput($sformatf("vec%0d_req", i), bus.imem_req, vecs[i].req);
            checkOutput($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].addr);
        end

        // Branch while a 3-cycle request for 0x14 is in flight: its response must be flushed.
        mem_fixed_lat = 3;
        applyStimulus(1, 0, 0, 64'h0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            applyStimulus(0, 0, 0, 64'h0);
            if (mem_pending && mem_addr == 64'h14 && mem_cnt >= 1) found = 1'b1;
        end
        checkOutput("reach_req14", found, 1);
        applyStimulus(0, 0, 1, 64'h103);
        checkOutput("flush_req", bus.imem_req, 0);
        checkOutput("flush_fv", fetch_valid, 0);
        low_cycles = 1;
        seen_req   = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, 64'h0);
            if (bus.imem_req === 1'b1 && !seen_req) begin
                seen_req = 1'b1;
                checkOutput("redirect_addr", bus.imem_addr, 64'h100);
            end else if (!seen_req) begin
                low_cycles++;
            end
            if (fetch_valid === 1'b1) found = 1'b1;
        end
        checkOutput("flush_low_cycles", low_cycles, 2);
        checkOutput("redirect_fv", fetch_valid, 1);
        checkOutput("redirect_first_pc", PC_Out, 64'h100);
        checkOutput("redirect_first_instr", Instruction, word_at(64'h100));

        // Reset while holding a skidded response, then a stray response during IDLE.
        mem_fixed_lat = 0;
        applyStimulus(1, 0, 0, 64'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, 64'h0);
            if (fetch_valid === 1'b1 && PC_Out == 64'h8) found = 1'b1;
        end
        checkOutput("reach_pc8", found, 1);
        applyStimulus(0, 1, 0, 64'h0);
        checkOutput("wait_req_low", bus.imem_req, 0);
        checkOutput("wait_pc", PC_Out, 64'h8);
        applyStimulus(1, 1, 0, 64'h0);
        checkOutput("rst_fv", fetch_valid, 0);
        checkOutput("rst_instr", Instruction, NOP);
        checkOutput("rst_pc", PC_Out, 64'h0);
        checkOutput("rst_adder", adder_out1, 64'h0);
        checkOutput("rst_req", bus.imem_req, 0);
        mem_auto    = 1'b0;
        force_valid = 1'b1;
        force_rdata = 32'hDEAD_BEEF;
        applyStimulus(0, 0, 0, 64'h0);
        mem_auto    = 1'b1;
        force_valid = 1'b0;
        checkOutput("stray_fv", fetch_valid, 0);
        checkOutput("post_rst_req", bus.imem_req, 1);
        checkOutput("post_rst_addr", bus.imem_addr, RESET_PC);
        applyStimulus(0, 0, 0, 64'h0);
        checkOutput("post_rst_fv", fetch_valid, 1);
        checkOutput("post_rst_pc", PC_Out, RESET_PC);
        checkOutput("post_rst_instr", Instruction, word_at(RESET_PC));

        // Random stalls, branches and memory latency against the program-order model.
        mem_rand = 1'b1;
        applyStimulus(1, 0, 0, 64'h0);
        start_transfers = transfers;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                tgt = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            else
                tgt = {$urandom, $urandom};
            applyStimulus(0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, tgt);
        end
        checkOutput("random_progress", (transfers - start_transfers) > 200, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
